audio_clk_nco: RTL and testbench

//  Parametrised multi-output audio clock generator: one phase-accumulator NCO per output, all on refclk.

---
 rtl/audio_clk_nco.sv | 136 +++++++++++++
 tb/tb_audio_clk_nco.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_clk_nco.sv
// audio_clk_nco: multi-output phase-accumulator audio clock generator.
// Ports: refclk/rst (sync, active-high); outclk/clk_en per channel; locked;
//   cfg_valid/cfg_ready/cfg_sel/cfg_inc run-time rate reprogramming.
// Macro AUDIO_NCO_RECONFIG_EN enables the cfg_* handshake; otherwise
//   cfg_ready is tied 0 and every channel runs at INC_INIT forever.
module audio_clk_nco #(
    parameter int                            NUM_CLOCKS  = 2,
    parameter int                            ACC_W       = 32,
    parameter logic [NUM_CLOCKS*ACC_W-1:0]   INC_INIT    = {32'd1055531163, 32'd969769256},
    parameter int                            LOCK_CYCLES = 1024
) (
    input  logic                          refclk,
    input  logic                          rst,
    output logic [NUM_CLOCKS-1:0]         outclk,
    output logic [NUM_CLOCKS-1:0]         clk_en,
    output logic                          locked,
    input  logic                          cfg_valid,
    output logic                          cfg_ready,
    input  logic [$clog2(NUM_CLOCKS):0]   cfg_sel,
    input  logic [ACC_W-1:0]              cfg_inc
);

    localparam int               SEL_W    = $clog2(NUM_CLOCKS) + 1;
    localparam int               CNT_W    = $clog2(LOCK_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_CYCLES - 1);
    // Half the accumulator range: fastest legal rate, toggles every cycle.
    localparam logic [ACC_W-1:0] INC_MAX  = {1'b1, {(ACC_W-1){1'b0}}};

    typedef enum logic {
        ST_COUNT,
        ST_LOCKED
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             cfg_xfer;
    logic             sel_ok;
    logic [ACC_W-1:0] inc_new;

`ifdef AUDIO_NCO_RECONFIG_EN
    assign cfg_xfer = cfg_valid & cfg_ready;
`else
    logic unused_cfg;
    assign unused_cfg = cfg_valid;
    assign cfg_xfer   = 1'b0;
`endif

    // Out-of-range selects complete the handshake but touch nothing.
    assign sel_ok  = (cfg_sel < SEL_W'(NUM_CLOCKS));
    assign inc_new = (cfg_inc > INC_MAX) ? INC_MAX : cfg_inc;

    // Lock FSM: state register
    always_ff @(posedge refclk) begin
        if (rst) begin
            state_q <= ST_COUNT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Lock FSM: next state
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_COUNT: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_LOCKED;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_LOCKED: begin
                if (cfg_xfer && sel_ok) begin
                    state_d = ST_COUNT;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_COUNT;
                cnt_d   = '0;
            end
        endcase
    end

    // Lock FSM: outputs
    always_comb begin
        locked = (state_q == ST_LOCKED);
`ifdef AUDIO_NCO_RECONFIG_EN
        cfg_ready = (state_q == ST_LOCKED);
`else
        cfg_ready = 1'b0;
`endif
    end

    for (genvar i = 0; i < NUM_CLOCKS; i++) begin : g_ch
        logic [ACC_W-1:0] acc_q;
        logic [ACC_W-1:0] inc_q;
        logic [ACC_W-1:0] acc_sum;
        logic             oc_q;
        logic             en_q;
        logic             load;

        assign load    = cfg_xfer & sel_ok & (cfg_sel == SEL_W'(i));
        // Wraps modulo 2^ACC_W by design.
        assign acc_sum = acc_q + inc_q;

        always_ff @(posedge refclk) begin
            if (rst) begin
                acc_q <= '0;
                inc_q <= INC_INIT[i*ACC_W +: ACC_W];
                oc_q  <= 1'b0;
                en_q  <= 1'b0;
            end else if (load) begin
                // Restart the channel from phase zero at the new rate.
                acc_q <= '0;
                inc_q <= inc_new;
                oc_q  <= 1'b0;
                en_q  <= 1'b0;
            end else begin
                acc_q <= acc_sum;
                oc_q  <= acc_sum[ACC_W-1];
                en_q  <= acc_sum[ACC_W-1] & ~oc_q;
            end
        end

        assign outclk[i] = oc_q;
        assign clk_en[i] = en_q;
    end

endmodule

// File: tb/tb_audio_clk_nco.sv
// tb_audio_clk_nco: scoreboard bench for audio_clk_nco.
// Stimulus queues cycle-tagged expectations; a negedge monitor checks them.
module tb_audio_clk_nco;

`ifdef AUDIO_NCO_RECONFIG_EN
    localparam bit EN = 1'b1;
`else
    localparam bit EN = 1'b0;
`endif

    localparam int K_ST  = 0;
    localparam int K_WIN = 1;
    localparam int K_CNT = 2;

    typedef struct {
        int         cyc;
        int         kind;
        string      name;
        logic [5:0] mask;
        logic [5:0] exp;
        int         ch;
        int         cexp;
        int         tol;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cfg_valid = 1'b0;
    logic [1:0]  cfg_sel = 2'd0;
    logic [31:0] cfg_inc = 32'd0;
    logic [1:0]  outclk;
    logic [1:0]  clk_en;
    logic        locked;
    logic        cfg_ready;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   cnt0 = 0;
    int   cnt1 = 0;
    int   last_push = 0;
    ent_t sb[$];

    audio_clk_nco #(
        .NUM_CLOCKS (2),
        .ACC_W      (32),
        .LOCK_CYCLES(1024)
    ) dut (
        .refclk   (clk),
        .rst      (rst),
        .outclk   (outclk),
        .clk_en   (clk_en),
        .locked   (locked),
        .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready),
        .cfg_sel  (cfg_sel),
        .cfg_inc  (cfg_inc)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void push(ent_t e);
        if (e.cyc < last_push) begin
            checks++;
            errors++;
            $display("FAIL order %s: due %0d after %0d", e.name, e.cyc, last_push);
        end
        sb.push_back(e);
        last_push = e.cyc;
    endfunction

    // Status bits: {cfg_ready, locked, clk_en[1], clk_en[0], outclk[1], outclk[0]}
    function automatic void push_st(int c, string n, logic [5:0] m, logic [5:0] x);
        ent_t e;
        e = '{cyc: c, kind: K_ST, name: n, mask: m, exp: x, ch: 0, cexp: 0, tol: 0};
        push(e);
    endfunction

    function automatic void push_win(int c);
        ent_t e;
        e = '{cyc: c, kind: K_WIN, name: "win", mask: 0, exp: 0, ch: 0, cexp: 0, tol: 0};
        push(e);
    endfunction

    function automatic void push_cnt(int c, string n, int ch, int x, int t);
        ent_t e;
        e = '{cyc: c, kind: K_CNT, name: n, mask: 0, exp: 0, ch: ch, cexp: x, tol: t};
        push(e);
    endfunction

    always @(negedge clk) begin
        logic [5:0] st;
        ent_t       e;
        int         got;
        st = {cfg_ready, locked, clk_en, outclk};
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            if (e.kind == K_WIN) begin
                cnt0 = 0;
                cnt1 = 0;
            end else begin
                checks++;
                if (e.cyc != cyc) begin
                    errors++;
                    $display("FAIL %s: checked at cycle %0d, due %0d", e.name, cyc, e.cyc);
                end else if (e.kind == K_ST) begin
                    if ((st & e.mask) !== (e.exp & e.mask)) begin
                        errors++;
                        $display("FAIL %s: cycle %0d status got %b expected %b mask %b",
                                 e.name, cyc, st, e.exp, e.mask);
                    end
                end else begin
                    got = (e.ch == 0) ? cnt0 : cnt1;
                    if (got < e.cexp - e.tol || got > e.cexp + e.tol) begin
                        errors++;
                        $display("FAIL %s: ch%0d clk_en count got %0d expected %0d +/- %0d",
                                 e.name, e.ch, got, e.cexp, e.tol);
                    end
                end
            end
        end
        cnt0 += int'(clk_en[0]);
        cnt1 += int'(clk_en[1]);
    end

    task automatic tick(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Post-reset pattern worked by hand from the default increments:
    // edge 3 both MSBs rise, edge 4 both high, edge 5 both wrap low.
    task automatic do_reset(int n, bit chk_lock);
        int r;
        rst = 1'b1;
        tick(n);
        r = cyc;
        rst = 1'b0;
        cfg_valid = 1'b0;
        push_st(r, "rst_state", 6'h3f, 6'b000000);
        push_st(r + 2, "acc_edge2", 6'h3f, 6'b000000);
        push_st(r + 3, "acc_edge3", 6'h3f, 6'b001111);
        push_st(r + 4, "acc_edge4", 6'h3f, 6'b000011);
        push_st(r + 5, "acc_edge5", 6'h3f, 6'b000000);
        if (chk_lock) begin
            push_st(r + 1023, "lock_pre", 6'b110000, 6'b000000);
            push_st(r + 1024, "lock_at", 6'b110000, {EN, 1'b1, 4'b0});
        end
    endtask

    task automatic rate_window(int n, string nm, int e0, int t0, int e1, int t1);
        int s;
        s = cyc + 1;
        push_win(s);
        push_cnt(s + n, {nm, "_ch0"}, 0, e0, t0);
        push_cnt(s + n, {nm, "_ch1"}, 1, e1, t1);
        tick(n + 1);
    endtask

    initial begin
        int t;
        int e;
        int u;
        int v;

        do_reset(4, 1'b1);
        tick(1024);
        rate_window(20000, "rate_default", 4516, 1, 4915, 1);

`ifdef AUDIO_NCO_RECONFIG_EN
        t = cyc;
        push_st(t, "s2_ready", 6'b110000, 6'b110000);
        cfg_valid = 1'b1;
        cfg_sel   = 2'd0;
        cfg_inc   = 32'h4000_0000;
        push_st(t + 1, "s2_accept", 6'b110101, 6'b000000);
        push_st(t + 2, "s2_ph2", 6'b000101, 6'b000000);
        push_win(t + 2);
        push_st(t + 3, "s2_ph3", 6'b000101, 6'b000101);
        push_st(t + 4, "s2_ph4", 6'b000101, 6'b000001);
        push_st(t + 5, "s2_ph5", 6'b000101, 6'b000000);
        push_st(t + 6, "s2_ph6", 6'b000101, 6'b000000);
        push_st(t + 7, "s2_ph7", 6'b000101, 6'b000101);
        push_cnt(t + 1002, "s2_ch0_div4", 0, 250, 0);
        push_cnt(t + 1002, "s2_ch1_undisturbed", 1, 246, 1);
        push_st(t + 1024, "s2_lock_pre", 6'b110000, 6'b000000);
        push_st(t + 1025, "s2_lock", 6'b110000, 6'b110000);
        tick(1);
        // Request held through COUNT; must stall until relocked.
        cfg_sel = 2'd1;
        cfg_inc = 32'd0;
        tick(1025);
        cfg_valid = 1'b0;
        push_st(t + 1026, "s3_halt_accept", 6'b111010, 6'b000000);
        push_win(t + 1027);
        push_st(t + 2049, "s3_lock_pre", 6'b110000, 6'b000000);
        push_st(t + 2050, "s3_lock", 6'b110000, 6'b110000);
        push_st(t + 5000, "s3_halt_mid", 6'b001010, 6'b000000);
        push_cnt(t + 11027, "s3_ch0_div4", 0, 2500, 0);
        push_cnt(t + 11027, "s3_ch1_halted", 1, 0, 0);
        tick(10001);
        e = cyc + 1;
        cfg_valid = 1'b1;
        cfg_sel   = 2'd1;
        cfg_inc   = 32'hFFFF_FFFF;
        push_st(e, "s3_clamp_accept", 6'b111010, 6'b000000);
        push_st(e + 1, "s3_clamp_e1", 6'b001010, 6'b001010);
        push_st(e + 2, "s3_clamp_e2", 6'b001010, 6'b000000);
        push_st(e + 3, "s3_clamp_e3", 6'b001010, 6'b001010);
        tick(1);
        cfg_valid = 1'b0;
        tick(1024);
        u = cyc;
        push_st(u, "s4_ready", 6'b110000, 6'b110000);
        cfg_valid = 1'b1;
        cfg_sel   = 2'd3;
        cfg_inc   = 32'h4000_0000;
        push_st(u + 1, "s4_bad_sel_held", 6'b110000, 6'b110000);
        push_st(u + 2, "s4_bad_sel_held2", 6'b110000, 6'b110000);
        push_win(u + 2);
        push_cnt(u + 1002, "s4_ch0_rate", 0, 250, 0);
        push_cnt(u + 1002, "s4_ch1_rate", 1, 500, 0);
        push_st(u + 1024, "s4_still_locked", 6'b110000, 6'b110000);
        tick(1);
        cfg_valid = 1'b0;
        tick(1023);
        v = cyc;
        cfg_valid = 1'b1;
        cfg_sel   = 2'd0;
        cfg_inc   = 32'd0;
        push_st(v + 1, "s5_enter_count", 6'b110001, 6'b000000);
        tick(1);
        cfg_valid = 1'b0;
        tick(500);
`else
        t = cyc;
        cfg_valid = 1'b1;
        cfg_sel   = 2'd0;
        cfg_inc   = 32'h4000_0000;
        push_st(t, "s6_no_ready0", 6'b110000, 6'b010000);
        push_st(t + 1, "s6_no_ready1", 6'b110000, 6'b010000);
        push_st(t + 2, "s6_no_ready2", 6'b110000, 6'b010000);
        tick(2);
        cfg_valid = 1'b0;
        rate_window(10000, "s6_rate", 2258, 1, 2458, 1);
        push_st(cyc, "s6_locked_kept", 6'b110000, 6'b010000);
        do_reset(1, 1'b0);
        tick(500);
`endif

        cfg_valid = 1'b1;
        cfg_sel   = 2'd1;
        cfg_inc   = 32'h4000_0000;
        do_reset(1, 1'b1);
        tick(1024);
        rate_window(10000, "s5_rate_restored", 2258, 1, 2458, 1);

        tick(2);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d pending checks, expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
